// File: rtl/ad7606_seq.sv
// ============================================================================
// ad7606_seq -- conversion/readout sequencer for the AD7606 8-channel ADC.
//
// Generates periodic CONVST pulses and waits out BUSY. It then reads CH_NUM
// channels with CS/RD strobes and buffers {channel, data} words in a FIFO.
// The FIFO feeds a valid/ready sample stream. Everything runs in the clk domain.
//
// Optional feature: define AD7606_BUSY_TO_EN to abort a frame when BUSY does
// not toggle within BUSY_TO cycles. The abort sets sync_err and resyncs the ADC.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   en                1 = run periodic sampling
//   os_sel            oversampling request, copied to ad_os while idle (WAIT)
//   ad_data/ad_busy/first_data   ADC parallel bus, BUSY and FRSTDATA pins
//   ad_os/ad_cs/ad_rd/ad_reset/ad_convstab   ADC control pins
//   smp_vaild/smp_ready/smp_data/smp_ch      sample stream
//   overrun           sticky: trigger missed or sample dropped on full FIFO
//   sync_err          sticky: first_data missing (or busy timeout)
//   clr_err           clears both sticky flags (a same-cycle event wins)
//   fsm_state         sequencer state, for debug and checkers
//
// Stream handshake: a word transfers on every rising clk edge where
// smp_vaild=1 and smp_ready=1. smp_vaild stays high while the FIFO holds data.
// smp_data/smp_ch show the head entry and do not change until it is taken.
// smp_vaild never depends combinationally on smp_ready.
// ============================================================================
module ad7606_seq #(
    parameter int CH_NUM     = 8,
    parameter int SAMPLE_DIV = 1000,
    parameter int CONV_LOW   = 2,
    parameter int RD_LOW     = 2,
    parameter int RD_HIGH    = 1,
    parameter int RESET_CYC  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int BUSY_TO    = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  os_sel,
    input  logic [15:0] ad_data,
    input  logic        ad_busy,
    input  logic        first_data,
    output logic [2:0]  ad_os,
    output logic        ad_cs,
    output logic        ad_rd,
    output logic        ad_reset,
    output logic        ad_convstab,
    output logic        smp_vaild,
    input  logic        smp_ready,
    output logic [15:0] smp_data,
    output logic [2:0]  smp_ch,
    output logic        overrun,
    output logic        sync_err,
    input  logic        clr_err,
    output logic [3:0]  fsm_state
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared phase timer covers every timed state, including the busy wait.
    localparam int TMAX = max2(max2(max2(RESET_CYC, CONV_LOW), max2(RD_LOW, RD_HIGH)), BUSY_TO);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RST    = 4'd1,
        S_WAIT   = 4'd2,
        S_CONV   = 4'd3,
        S_BUSY_H = 4'd4,
        S_BUSY_L = 4'd5,
        S_RD_L   = 4'd6,
        S_RD_H   = 4'd7,
        S_END    = 4'd8
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmr, tmr_last;
    logic            tmr_done;
    logic [2:0]      ch;
    logic            last_ch;
    logic [PW-1:0]   pcnt;
    logic            wrap, pend, wrap_drop;
    logic            capture, bad_first, push, pop, full, wr_en;
    logic            bto_hit, bto_abort;
    logic            ovr_evt, sync_evt;
    logic [18:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic [18:0]     head;

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Phase timer end value for the current state
    // ------------------------------------------------------------------
    always_comb begin
        tmr_last = '0;
        case (state)
            S_RST:   tmr_last = TW'(RESET_CYC - 1);
            S_CONV:  tmr_last = TW'(CONV_LOW - 1);
            S_RD_L:  tmr_last = TW'(RD_LOW - 1);
            S_RD_H:  tmr_last = TW'(RD_HIGH - 1);
            default: tmr_last = '0;
        endcase
    end

    assign tmr_done = (tmr == tmr_last);
    assign last_ch  = (ch == 3'(CH_NUM - 1));

    // The data word is latched on the edge that ends the RD low phase.
    assign capture   = (state == S_RD_L) && tmr_done;
    assign bad_first = capture && (ch == 3'd0) && !first_data;
    assign push      = capture && !bad_first;

`ifdef AD7606_BUSY_TO_EN
    // The timer restarts on every state change, so it counts time spent in
    // the current busy phase.
    assign bto_hit = (tmr == TW'(BUSY_TO - 1));
`else
    assign bto_hit = 1'b0;
`endif

    assign bto_abort = bto_hit && (((state == S_BUSY_H) && !ad_busy) ||
                                   ((state == S_BUSY_L) &&  ad_busy));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = S_RST;
            S_RST:    if (tmr_done) state_n = S_WAIT;
            S_WAIT:   if (en && pend) state_n = S_CONV;
            S_CONV:   if (tmr_done) state_n = S_BUSY_H;
            S_BUSY_H: begin
                if (ad_busy)      state_n = S_BUSY_L;
                else if (bto_hit) state_n = S_RST;
            end
            S_BUSY_L: begin
                if (!ad_busy)     state_n = S_RD_L;
                else if (bto_hit) state_n = S_RST;
            end
            S_RD_L:   if (tmr_done) state_n = bad_first ? S_RST : S_RD_H;
            S_RD_H:   if (tmr_done) state_n = last_ch ? S_END : S_RD_L;
            S_END:    state_n = S_WAIT;
            default:  state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: ADC pin outputs, decoded from the registered state.
    // A resync (RST) always leaves CS and CONVST released.
    // ------------------------------------------------------------------
    always_comb begin
        ad_cs       = 1'b1;
        ad_rd       = 1'b1;
        ad_convstab = 1'b1;
        ad_reset    = 1'b0;
        case (state)
            S_RST:   ad_reset    = 1'b1;
            S_CONV:  ad_convstab = 1'b0;
            S_RD_L:  begin
                ad_cs = 1'b0;
                ad_rd = 1'b0;
            end
            S_RD_H:  ad_cs = 1'b0;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Period counter and one-deep trigger flag. A trigger only registers
    // while the sequencer idles in WAIT with no trigger already queued.
    // ------------------------------------------------------------------
    assign wrap      = en && (pcnt == PW'(SAMPLE_DIV - 1));
    assign wrap_drop = wrap && (pend || (state != S_WAIT));

    // ------------------------------------------------------------------
    // FIFO control: a pop in the same cycle frees the slot for a push.
    // ------------------------------------------------------------------
    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign smp_vaild = (count != '0);
    assign pop       = smp_vaild && smp_ready;
    assign wr_en     = push && (!full || pop);
    assign head      = mem[rptr];
    assign smp_data  = smp_vaild ? head[15:0]  : 16'h0000;
    assign smp_ch    = smp_vaild ? head[18:16] : 3'd0;

    assign ovr_evt  = (push && full && !pop) || wrap_drop;
    assign sync_evt = bad_first || bto_abort;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= {ch, ad_data};
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr      <= '0;
            ch       <= 3'd0;
            pcnt     <= '0;
            pend     <= 1'b0;
            ad_os    <= 3'd0;
            overrun  <= 1'b0;
            sync_err <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            if (state_n != state) tmr <= '0;
            else                  tmr <= tmr + 1'b1;

            if ((state == S_BUSY_L) && (state_n == S_RD_L))
                ch <= 3'd0;
            else if ((state == S_RD_H) && (state_n == S_RD_L))
                ch <= ch + 3'd1;

            if (!en || wrap) pcnt <= '0;
            else             pcnt <= pcnt + 1'b1;

            if ((state == S_WAIT) && (state_n == S_CONV))
                pend <= 1'b0;
            else if (wrap && (state == S_WAIT) && !pend)
                pend <= 1'b1;

            if (state == S_WAIT) ad_os <= os_sel;

            // Error events take priority over a same-cycle clear.
            if (ovr_evt)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;

            if (sync_evt)     sync_err <= 1'b1;
            else if (clr_err) sync_err <= 1'b0;

            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606_seq.sv
// ============================================================================
// tb_ad7606_seq -- self-checking bench for ad7606_seq.
//
// An ADC model drives BUSY, the data bus and FRSTDATA from the DUT strobes.
// A queue-based reference predicts the sample stream from the read pulses.
// It applies the FIFO capacity and first_data rules.
// A second DUT instance with a short trigger period exercises trigger overrun.
// ============================================================================
module tb_ad7606_seq;

    localparam int BUSY_CYC    = 20;
    localparam int DEPTH       = 16;
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_WAIT   = 4'd2;
    localparam logic [3:0] ST_BUSY_H = 4'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic        en, ad_busy, first_data, smp_ready, clr_err;
    logic [2:0]  os_sel;
    logic [15:0] ad_data;
    logic [2:0]  ad_os, smp_ch;
    logic        ad_cs, ad_rd, ad_reset, ad_convstab, smp_vaild, overrun, sync_err;
    logic [15:0] smp_data;
    logic [3:0]  fsm_state;

    ad7606_seq u_dut (
        .clk(clk), .reset(rst_n), .en(en), .os_sel(os_sel), .ad_data(ad_data),
        .ad_busy(ad_busy), .first_data(first_data), .ad_os(ad_os), .ad_cs(ad_cs),
        .ad_rd(ad_rd), .ad_reset(ad_reset), .ad_convstab(ad_convstab),
        .smp_vaild(smp_vaild), .smp_ready(smp_ready), .smp_data(smp_data),
        .smp_ch(smp_ch), .overrun(overrun), .sync_err(sync_err), .clr_err(clr_err),
        .fsm_state(fsm_state)
    );

    // ---------------- fast-trigger DUT ----------------
    logic        en_f, busy_f;
    logic [2:0]  ad_os_f, smp_ch_f;
    logic        cs_f, rd_f, rst_pin_f, cv_f, vaild_f, ovr_f, sync_f;
    logic [15:0] smp_data_f;
    logic [3:0]  state_f;

    ad7606_seq #(.SAMPLE_DIV(30)) u_fast (
        .clk(clk), .reset(rst_n), .en(en_f), .os_sel(3'd0), .ad_data(16'h1234),
        .ad_busy(busy_f), .first_data(1'b1), .ad_os(ad_os_f), .ad_cs(cs_f),
        .ad_rd(rd_f), .ad_reset(rst_pin_f), .ad_convstab(cv_f),
        .smp_vaild(vaild_f), .smp_ready(1'b1), .smp_data(smp_data_f),
        .smp_ch(smp_ch_f), .overrun(ovr_f), .sync_err(sync_f), .clr_err(1'b0),
        .fsm_state(state_f)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [18:0] exp_q[$];
    logic exp_ovr, exp_sync;
    logic ready_req;

    // ADC model state (main)
    logic prev_rd, prev_cv, cur_fd, fd_ok, busy_stuck, rnd_data;
    logic [15:0] base, cur_data;
    int busy_left, idx, rd_w, rd_w_bad, n_rd, n_conv, conv_cyc, conv_cyc_prev;
    int conflict, frame_pops;
    // ADC model state (fast)
    logic prev_cv_f;
    int busy_left_f, n_conv_f, conflict_f;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"},       ad_cs, 1);
        check({tag, "_rd"},       ad_rd, 1);
        check({tag, "_convst"},   ad_convstab, 1);
        check({tag, "_adreset"},  ad_reset, 0);
        check({tag, "_os"},       ad_os, 0);
        check({tag, "_vaild"},    smp_vaild, 0);
        check({tag, "_data"},     smp_data, 0);
        check({tag, "_ch"},       smp_ch, 0);
        check({tag, "_overrun"},  overrun, 0);
        check({tag, "_sync_err"}, sync_err, 0);
        check({tag, "_state"},    fsm_state, ST_IDLE);
    endtask

    // ADC behaviour plus reference prediction, evaluated once per negedge.
    task automatic adc_step();
        if (!ad_convstab && prev_cv) begin
            n_conv++;
            conv_cyc_prev = conv_cyc;
            conv_cyc = cyc;
            idx = 0;
            base = rnd_data ? 16'($urandom) : 16'hF00F;
            if (!busy_stuck) begin
                ad_busy = 1'b1;
                busy_left = BUSY_CYC;
            end
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) ad_busy = 1'b0;
        end
        if (!ad_convstab && !ad_cs) conflict++;

        if (!ad_rd && prev_rd) begin
            cur_data   = base + 16'(idx);
            cur_fd     = (idx == 0) && fd_ok;
            ad_data    = cur_data;
            first_data = cur_fd;
            rd_w       = 1;
        end else if (!ad_rd) begin
            rd_w++;
        end
        if (ad_rd && !prev_rd) begin
            // The DUT latched the word on the edge just before this negedge.
            if (rd_w != 2) rd_w_bad++;
            n_rd++;
            if (idx == 0 && !cur_fd) begin
                exp_sync = 1'b1;
            end else if (exp_q.size() < DEPTH) begin
                exp_q.push_back({3'(idx), cur_data});
                check("capture_latency", smp_vaild, 1);
            end else begin
                exp_ovr = 1'b1;
            end
            idx++;
        end
        prev_rd = ad_rd;
        prev_cv = ad_convstab;
    endtask

    task automatic fast_step();
        if (!cv_f && prev_cv_f) begin
            n_conv_f++;
            busy_f = 1'b1;
            busy_left_f = BUSY_CYC;
        end else if (busy_left_f > 0) begin
            busy_left_f--;
            if (busy_left_f == 0) busy_f = 1'b0;
        end
        if (!cv_f && !cs_f) conflict_f++;
        prev_cv_f = cv_f;
    endtask

    task automatic monitor();
        logic [18:0] want;
        if (smp_vaild === 1'b1 && smp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_sample: got ch=%0d data=0x%0h, want none", smp_ch, smp_data);
            end else begin
                want = exp_q.pop_front();
                check("sample", {13'd0, smp_ch, smp_data}, {13'd0, want});
                frame_pops++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        adc_step();
        fast_step();
        smp_ready = ready_req;
        monitor();
    endtask

    task automatic wait_conv(input string name, input int budget);
        int c0, t;
        c0 = n_conv;
        t = 0;
        while (n_conv == c0 && t < budget) begin
            tick();
            t++;
        end
        check({name, "_in_time"}, (t < budget), 1);
    endtask

    task automatic wait_pops(input string name, input int want, input int budget);
        int t;
        t = 0;
        while (frame_pops < want && t < budget) begin
            tick();
            t++;
        end
        check({name, "_in_time"}, (t < budget), 1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        tick();
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_sync = 1'b0;
        tick();
    endtask

    // ---------------- table of idle-state vectors ----------------
    typedef struct {
        logic [2:0] os;
        logic [2:0] exp_os;
        logic       exp_cs;
        logic       exp_cv;
        logic [3:0] exp_st;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main sequence ----------------
    initial begin
        int n_hi, pin_bad, t, n_rd0;
        logic saw_rst;

        vecs[0] = '{os: 3'd5, exp_os: 3'd5, exp_cs: 1'b1, exp_cv: 1'b1, exp_st: ST_WAIT};
        vecs[1] = '{os: 3'd2, exp_os: 3'd2, exp_cs: 1'b1, exp_cv: 1'b1, exp_st: ST_WAIT};
        vecs[2] = '{os: 3'd7, exp_os: 3'd7, exp_cs: 1'b1, exp_cv: 1'b1, exp_st: ST_WAIT};
        vecs[3] = '{os: 3'd0, exp_os: 3'd0, exp_cs: 1'b1, exp_cv: 1'b1, exp_st: ST_WAIT};
        vecs[4] = '{os: 3'd3, exp_os: 3'd3, exp_cs: 1'b1, exp_cv: 1'b1, exp_st: ST_WAIT};
        vecs[5] = '{os: 3'd6, exp_os: 3'd6, exp_cs: 1'b1, exp_cv: 1'b1, exp_st: ST_WAIT};

        rst_n = 1'b0; en = 1'b0; en_f = 1'b0; os_sel = 3'd0; ad_data = 16'h0;
        ad_busy = 1'b0; first_data = 1'b0; smp_ready = 1'b0; clr_err = 1'b0;
        busy_f = 1'b0; ready_req = 1'b0; exp_ovr = 1'b0; exp_sync = 1'b0;
        prev_rd = 1'b1; prev_cv = 1'b1; prev_cv_f = 1'b1; cur_fd = 1'b0;
        fd_ok = 1'b1; busy_stuck = 1'b0; rnd_data = 1'b0; base = 16'hF00F;
        cur_data = 16'h0; busy_left = 0; idx = 0; rd_w = 0; rd_w_bad = 0;
        n_rd = 0; n_conv = 0; conv_cyc = 0; conv_cyc_prev = 0; conflict = 0;
        frame_pops = 0; busy_left_f = 0; n_conv_f = 0; conflict_f = 0;

        // Reset state, then power-up ADC reset pulse with en=0.
        repeat (3) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        n_hi = 0;
        pin_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ad_reset) n_hi++;
            if (!ad_cs || !ad_convstab) pin_bad++;
        end
        check("pwrup_reset_len", n_hi, 4);
        check("pwrup_pins_idle", pin_bad, 0);
        check("pwrup_state_wait", fsm_state, ST_WAIT);
        en_f = 1'b1;

        // Idle vectors: ad_os follows os_sel while in WAIT.
        foreach (vecs[i]) begin
            os_sel = vecs[i].os;
            tick();
            tick();
            check("tbl_os", ad_os, vecs[i].exp_os);
            check("tbl_cs", ad_cs, vecs[i].exp_cs);
            check("tbl_convst", ad_convstab, vecs[i].exp_cv);
            check("tbl_state", fsm_state, vecs[i].exp_st);
        end

        // Normal frames with a ready consumer.
        os_sel = 3'b010;
        en = 1'b1;
        ready_req = 1'b1;
        wait_conv("frame1_conv", 1200);
        check("frame1_os", ad_os, 3'b010);
        frame_pops = 0;
        n_rd0 = n_rd;
        wait_pops("frame1_pops", 8, 300);
        check("frame1_rd_pulses", n_rd - n_rd0, 8);
        check("frame1_rd_width", rd_w_bad, 0);
        wait_conv("frame2_conv", 1200);
        check("convst_period", conv_cyc - conv_cyc_prev, 1000);
        frame_pops = 0;
        wait_pops("frame2_pops", 8, 300);

        // Stalled consumer for three frames: FIFO keeps the oldest 16.
        ready_req = 1'b0;
        n_rd0 = n_rd;
        t = 0;
        while (n_rd - n_rd0 < 24 && t < 3500) begin
            tick();
            t++;
        end
        check("stall_in_time", (t < 3500), 1);
        repeat (5) tick();
        check("stall_overrun", overrun, 1);
        check("stall_overrun_model", overrun, exp_ovr);
        check("stall_vaild", smp_vaild, 1);
        en = 1'b0;
        repeat (10) tick();
        frame_pops = 0;
        ready_req = 1'b1;
        repeat (40) tick();
        check("drain_count", frame_pops, 16);
        check("drain_empty", smp_vaild, 0);
        pulse_clr();
        check("clr_overrun", overrun, 0);

        // Missing first_data: sample discarded and ADC resynced.
        fd_ok = 1'b0;
        en = 1'b1;
        frame_pops = 0;
        wait_conv("fd_conv", 1200);
        t = 0;
        while (!ad_reset && t < 200) begin
            tick();
            t++;
        end
        check("fd_resync_in_time", (t < 200), 1);
        check("fd_sync_err", sync_err, 1);
        check("fd_sync_model", sync_err, exp_sync);
        check("fd_no_sample", smp_vaild, 0);
        n_hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (ad_reset) n_hi++;
            tick();
        end
        check("fd_reset_len", n_hi, 4);
        fd_ok = 1'b1;
        wait_conv("fd_recover_conv", 1200);
        frame_pops = 0;
        wait_pops("fd_recover_pops", 8, 300);
        pulse_clr();
        check("clr_sync_err", sync_err, 0);

        // Randomised data and consumer back-pressure.
        rnd_data = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            ready_req = ($urandom_range(0, 3) != 0);
            tick();
        end
        ready_req = 1'b1;
        repeat (100) tick();
        check("rand_leftover", exp_q.size(), 0);
        check("rand_overrun", overrun, exp_ovr);
        check("rand_sync_err", sync_err, exp_sync);
        check("rand_rd_width", rd_w_bad, 0);
        rnd_data = 1'b0;

        // Short trigger period instance.
        check("fast_overrun", ovr_f, 1);
        check("fast_no_conv_during_cs", conflict_f, 0);
        check("fast_frames_run", (n_conv_f > 10), 1);
        check("main_no_conv_during_cs", conflict, 0);

        // BUSY never rises.
        busy_stuck = 1'b1;
        wait_conv("stuck_conv", 1200);
        saw_rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ad_reset) saw_rst = 1'b1;
        end
`ifdef AD7606_BUSY_TO_EN
        check("bto_sync_err", sync_err, 1);
        check("bto_resync", saw_rst, 1);
`else
        check("stuck_state", fsm_state, ST_BUSY_H);
        check("stuck_no_sync_err", sync_err, 0);
        check("stuck_no_resync", saw_rst, 0);
`endif

        // Reset in the middle of a frame.
        rst_n = 1'b0;
        tick();
        check_reset_vals("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ad7606_seq.md
Name: ad7606_seq

Overview:
- Sequencer for the AD7606 8-channel ADC.
- Generates periodic conversion starts, waits out BUSY, and reads all channels with CS/RD strobes.
- Buffers the samples in an internal FIFO and presents them on a valid/ready stream to the commit datapath.
- Sits between the board-level ad_* pins and the instruction/commit logic, all in the clk domain.

Parameters:
- CH_NUM, 8: channels read per frame (1..8).
- SAMPLE_DIV, 1000: clk cycles between conversion triggers.
- CONV_LOW, 2: cycles ad_convstab is held low.
- RD_LOW, 2: cycles ad_rd is held low per channel.
- RD_HIGH, 1: cycles ad_rd is held high between channels.
- RESET_CYC, 4: cycles ad_reset is held high at power-up or resync.
- FIFO_DEPTH, 16: sample FIFO entries (power of two).
- BUSY_TO, 200: busy timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- en  in  1  1 = run periodic sampling
- os_sel  in  3  oversampling ratio request
- ad_data  in  16  ADC parallel data
- ad_busy  in  1  ADC busy
- first_data  in  1  ADC first-channel flag
- ad_os  out  3  oversampling ratio pins
- ad_cs  out  1  chip select, active low
- ad_rd  out  1  read strobe, active low
- ad_reset  out  1  ADC reset, active high
- ad_convstab  out  1  conversion start, active low
- smp_vaild  out  1  sample available
- smp_ready  in  1  consumer accepts sample
- smp_data  out  16  sample value
- smp_ch  out  3  channel index of smp_data
- overrun  out  1  sticky: trigger missed or FIFO full
- sync_err  out  1  sticky: first_data missing or busy timeout
- clr_err  in  1  clears overrun and sync_err

Behaviour:
- Reset values: ad_cs=1, ad_rd=1, ad_convstab=1, ad_reset=0, ad_os=0, smp_vaild=0, smp_data=0, smp_ch=0, overrun=0, sync_err=0. FIFO empty, FSM in IDLE, period counter 0.
- Asserting reset mid-frame aborts the frame immediately. All outputs return to their reset values.
- FSM states and transitions:
  - IDLE: go to RST next cycle.
  - RST: ad_reset=1 for RESET_CYC cycles, then go to WAIT.
  - WAIT: ad_os <= os_sel, updated every cycle in this state only. Go to CONV when en=1 and a trigger is pending.
  - CONV: ad_convstab=0 for CONV_LOW cycles, then go to BUSY_H.
  - BUSY_H: wait for ad_busy=1, then go to BUSY_L.
  - BUSY_L: wait for ad_busy=0. Then ad_cs=0, channel index=0, go to RD_L.
  - RD_L: ad_rd=0 for RD_LOW cycles. ad_data is captured on the clk edge where ad_rd returns high; capture and FIFO push happen in the same edge.
  - RD_H: ad_rd=1 for RD_HIGH cycles. Then go to RD_L for the next channel, or to END after channel CH_NUM-1.
  - END: ad_cs=1, go to WAIT.
- Period counter:
  - Free-runs 0..SAMPLE_DIV-1 while en=1 and is held at 0 while en=0.
  - Wrap sets a one-deep trigger pending flag, cleared on entry to CONV.
  - A wrap while the flag is already set or the FSM is outside WAIT sets overrun; the extra trigger is dropped.
- first_data check: on the channel-0 capture, if first_data=0, set sync_err, discard the sample, force ad_cs=1 and go to RST.
- FIFO:
  - Each push stores {channel, data}.
  - Push when full: sample dropped, overrun set. The frame continues.
  - smp_vaild=1 whenever the FIFO is non-empty. smp_data/smp_ch show the head entry and stay stable while smp_vaild=1 and smp_ready=0.
  - Pop on smp_vaild & smp_ready.
  - Simultaneous push and pop when full: the pop frees the slot, the push succeeds, no overrun.
  - Latency: a sample is visible on smp_vaild the cycle after the capture edge.
- Error flags: clr_err clears overrun and sync_err. If clr_err and a new error event occur in the same cycle, the flag ends up set.
- en deasserted mid-frame: the current frame completes, then the FSM stays in WAIT.

Optional Feature:
- Macro: AD7606_BUSY_TO_EN.
- Defined: a counter runs in BUSY_H and BUSY_L. If it reaches BUSY_TO before the awaited edge, set sync_err, force ad_convstab=1 and ad_cs=1, and go to RST.
- Not defined: BUSY_H and BUSY_L wait indefinitely. The BUSY_TO parameter is unused and sync_err is driven only by the first_data check.

Test Plan:
- Reset released, en=0 -> ad_reset high for exactly 4 cycles, then FSM sits in WAIT; ad_convstab=1 and ad_cs=1 throughout.
- en=1, os_sel=3'b010, busy model 20 cycles, ad_data=16'hF00F+ch, first_data on ch0, smp_ready=1 -> ad_os=3'b010; 8 samples F00F..F016 with smp_ch 0..7 in order; 8 RD_L pulses each 2 cycles low; next convst 1000 cycles after the previous one.
- smp_ready=0 for 3 frames (24 samples) -> first 16 samples retained, overrun=1; after smp_ready=1 the 16 retained samples drain in order; clr_err pulse -> overrun=0.
- first_data held 0 -> sync_err=1, no sample pushed, ad_reset pulse re-issued, sampling resumes next trigger after the first_data fix.
- SAMPLE_DIV=30 while a frame needs more than 30 cycles -> overrun=1, no convst issued while ad_cs=0.
- With AD7606_BUSY_TO_EN, ad_busy stuck 0 -> sync_err=1 after 200 cycles in BUSY_H, FSM returns to RST; without the macro the FSM stays in BUSY_H.
